pipeline_controller: RTL
========================

# pipeline_controller

Control path of the five-stage RV32I pipeline. Decodes the Decode-stage instruction fields into control signals and carries them through the E, M and W control registers, so each stage sees the controls of the instruction it holds. Resolves branches and jumps in E from `ZeroE` and drives `PCSrcE` back to fetch. It feeds the datapath and exports the stage-tagged signals the hazard unit needs.

## Interface
- No parameters; all widths are fixed by the datapath encodings.

Ports:
- `clk`  in  1  pipeline clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears every control register.
- `opcode`  in  7  instruction[6:0] in D.
- `funct3`  in  3  instruction[14:12] in D.
- `funct7`  in  7  instruction[31:25] in D.
- `ZeroE`  in  1  ALU zero flag of the instruction in E.
- `FlushE`  in  1  from the hazard unit; turns the D→E capture into a bubble.
- `ImmSrcD`  out  3  immediate format for the instruction in D.
- `ALUSrcE`  out  1  0 = register, 1 = immediate.
- `ALUControlE`  out  3  ALU operation.
- `jalrE`  out  1  PC target base is RD1E instead of PCE.
- `PCSrcE`  out  1  redirect fetch to PCTargetE.
- `MemWriteM`  out  1  store enable.
- `RegWriteM`  out  1  for forwarding.
- `RegWriteW`  out  1  register-file write enable.
- `ResultSrcE0`  out  1  ResultSrcE[0]; flags a load in E for load-use stall detection.
- `ResultSrcW`  out  2  writeback select.
- `IllegalD`  out  1  unsupported opcode or funct combination in D.

## Operation
- Encodings:
  - ImmSrc: 000 I, 001 S, 010 B, 011 J, 100 U.
  - ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 pass-B.
  - ResultSrc: 00 ALU, 01 memory, 10 PC+4.
- Decode in D is combinational:
  - R-type (0110011): add, sub when funct7[5]=1, and, or, xor, slt, sltu. Any other funct7 is illegal.
  - I-ALU (0010011): addi, andi, ori, xori, slti, sltiu.
  - lw (0000011): funct3 must be 010.
  - sw (0100011): funct3 must be 010.
  - Branch (1100011):
    - beq and bne use sub.
    - blt and bge use slt.
    - bltu and bgeu use sltu.
  - jal (1101111): ResultSrc=10, Jump=1.
  - jalr (1100111): ResultSrc=10, Jump=1, Jalr=1, ALUSrc=1, ImmSrc=I.
  - lui (0110111): ImmSrc=U, ALUSrc=1, ALUControl=111, RegWrite=1.
- Illegal instructions assert `IllegalD` and force RegWrite, MemWrite, Jump and Branch to 0, so they pass down the pipe as NOPs.
- D→E register holds: RegWrite, ResultSrc, MemWrite, Jump, Branch, BranchF3 (funct3), ALUControl, ALUSrc, Jalr.
- E→M register holds: RegWrite, ResultSrc, MemWrite.
- M→W register holds: RegWrite, ResultSrc.
- Branch resolution, combinational in E:
  - Taken when beq & Z, bne & !Z, blt/bltu & !Z, or bge/bgeu & Z.
  - `PCSrcE` = JumpE | (BranchE & taken).
- `FlushE`=1 at a clock edge loads all D→E fields with 0. This overrides the decoded values.
- The E→M and M→W registers never stall or flush. A bubble propagates as all-zero controls.

## Timing
- Reset (asynchronous, immediate): all registered outputs go to 0. This gives `PCSrcE`=0, `MemWriteM`=0, `RegWriteM`=0, `RegWriteW`=0, `ResultSrcW`=00, `ALUControlE`=000, `jalrE`=0, `ALUSrcE`=0, `ResultSrcE0`=0.
  - `ImmSrcD` and `IllegalD` still follow their inputs, because they are combinational.
  - Reset asserted mid-operation discards all in-flight controls in the same cycle.
- Latency:
  - Instruction in D at cycle n: E controls are valid in n+1, M controls in n+2, W controls in n+3.
  - `PCSrcE` is valid in cycle n+1, in the same cycle as `ZeroE`.
- FlushE asserted together with a taken branch in E: `PCSrcE` still reflects the instruction currently in E. Only the incoming D instruction is bubbled.
- Back-to-back flushes each insert one bubble. There is no internal state beyond the pipeline registers: no FSM and no counters.

## Test plan
- Reset asserted between clock edges → all registered outputs read 0 immediately. After release, `add x1,x2,x3` in D gives `RegWriteW`=1 and `ResultSrcW`=00 exactly 3 edges later.
- `sw` (opcode 0100011, funct3 010) → `ImmSrcD`=001 in D. One edge later: `ALUSrcE`=1, `ALUControlE`=000. Two edges later: `MemWriteM`=1, `RegWriteM`=0.
- `bne` with ZeroE=0 in E → `PCSrcE`=1. With ZeroE=1 → 0. `bge` with ZeroE=1 → `PCSrcE`=1 and `ALUControlE`=101.
- `jalr` → `jalrE`=1, `PCSrcE`=1 regardless of ZeroE, and `ResultSrcW`=10 three edges after D.
- `lw` in D with `FlushE`=1 at the edge → `ResultSrcE0`=0 and `RegWriteM`/`RegWriteW` stay 0 down the pipe. With no flush → `ResultSrcE0`=1.
- opcode 1111111 → `IllegalD`=1, and all write enables are 0 in E, M and W.

Source files
------------

// File: rtl/pipeline_controller_if.sv
//------------------------------------------------------------------------------
// Module  : pipeline_controller_if
// Brief   : Datapath/hazard-unit side bundle of the RV32I pipeline control path.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipeline_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       ZeroE;
    logic       FlushE;
    logic [2:0] ImmSrcD;
    logic       ALUSrcE;
    logic [2:0] ALUControlE;
    logic       jalrE;
    logic       PCSrcE;
    logic       MemWriteM;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       ResultSrcE0;
    logic [1:0] ResultSrcW;
    logic       IllegalD;

    modport master (
        output opcode, funct3, funct7, ZeroE, FlushE,
        input  ImmSrcD, ALUSrcE, ALUControlE, jalrE, PCSrcE, MemWriteM,
               RegWriteM, RegWriteW, ResultSrcE0, ResultSrcW, IllegalD
    );

    modport slave (
        input  opcode, funct3, funct7, ZeroE, FlushE,
        output ImmSrcD, ALUSrcE, ALUControlE, jalrE, PCSrcE, MemWriteM,
               RegWriteM, RegWriteW, ResultSrcE0, ResultSrcW, IllegalD
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_controller.sv
//------------------------------------------------------------------------------
// Module  : pipeline_controller
// Brief   : RV32I decoder plus D->E->M->W control registers and branch resolve.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_controller (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_controller_if.slave bus
);
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_XOR  = 3'b100;
    localparam logic [2:0] c_ALU_SLT  = 3'b101;
    localparam logic [2:0] c_ALU_SLTU = 3'b110;
    localparam logic [2:0] c_ALU_PASS = 3'b111;

    localparam logic [1:0] c_RES_ALU = 2'b00;
    localparam logic [1:0] c_RES_MEM = 2'b01;
    localparam logic [1:0] c_RES_PC4 = 2'b10;

    // Raw decode before illegal-instruction gating
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_jump;
    logic       w_branch;
    logic       w_jalr;
    logic       w_alu_src;
    logic       w_legal;
    logic [1:0] w_result_src;
    logic [2:0] w_alu_ctrl;
    logic [2:0] w_imm_src;

    logic       reg_write_e_d, reg_write_e_q;
    logic       mem_write_e_d, mem_write_e_q;
    logic       jump_e_d,      jump_e_q;
    logic       branch_e_d,    branch_e_q;
    logic       jalr_e_d,      jalr_e_q;
    logic       alu_src_e_d,   alu_src_e_q;
    logic [1:0] result_src_e_d, result_src_e_q;
    logic [2:0] alu_ctrl_e_d,  alu_ctrl_e_q;
    logic [2:0] branch_f3_e_d, branch_f3_e_q;

    logic       reg_write_m_q, mem_write_m_q;
    logic [1:0] result_src_m_q;
    logic       reg_write_w_q;
    logic [1:0] result_src_w_q;

    logic       w_taken;

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_jump       = 1'b0;
        w_branch     = 1'b0;
        w_jalr       = 1'b0;
        w_alu_src    = 1'b0;
        w_legal      = 1'b0;
        w_result_src = c_RES_ALU;
        w_alu_ctrl   = c_ALU_ADD;
        w_imm_src    = c_IMM_I;
        case (bus.opcode)
            c_OP_R: begin
                w_reg_write = 1'b1;
                w_legal     = (bus.funct7 == 7'b0000000);
                case (bus.funct3)
                    3'b000: begin
                        w_alu_ctrl = bus.funct7[5] ? c_ALU_SUB : c_ALU_ADD;
                        w_legal    = (bus.funct7 == 7'b0000000) || (bus.funct7 == 7'b0100000);
                    end
                    3'b111:  w_alu_ctrl = c_ALU_AND;
                    3'b110:  w_alu_ctrl = c_ALU_OR;
                    3'b100:  w_alu_ctrl = c_ALU_XOR;
                    3'b010:  w_alu_ctrl = c_ALU_SLT;
                    3'b011:  w_alu_ctrl = c_ALU_SLTU;
                    default: w_legal    = 1'b0;
                endcase
            end
            c_OP_I: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_legal     = 1'b1;
                case (bus.funct3)
                    3'b000:  w_alu_ctrl = c_ALU_ADD;
                    3'b111:  w_alu_ctrl = c_ALU_AND;
                    3'b110:  w_alu_ctrl = c_ALU_OR;
                    3'b100:  w_alu_ctrl = c_ALU_XOR;
                    3'b010:  w_alu_ctrl = c_ALU_SLT;
                    3'b011:  w_alu_ctrl = c_ALU_SLTU;
                    default: w_legal    = 1'b0;
                endcase
            end
            c_OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = c_RES_MEM;
                w_legal      = (bus.funct3 == 3'b010);
            end
            c_OP_SW: begin
                w_imm_src   = c_IMM_S;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_legal     = (bus.funct3 == 3'b010);
            end
            c_OP_BR: begin
                w_imm_src = c_IMM_B;
                w_branch  = 1'b1;
                w_legal   = 1'b1;
                case (bus.funct3)
                    3'b000, 3'b001: w_alu_ctrl = c_ALU_SUB;
                    3'b100, 3'b101: w_alu_ctrl = c_ALU_SLT;
                    3'b110, 3'b111: w_alu_ctrl = c_ALU_SLTU;
                    default:        w_legal    = 1'b0;
                endcase
            end
            c_OP_JAL: begin
                w_imm_src    = c_IMM_J;
                w_reg_write  = 1'b1;
                w_result_src = c_RES_PC4;
                w_jump       = 1'b1;
                w_legal      = 1'b1;
            end
            c_OP_JALR: begin
                w_imm_src    = c_IMM_I;
                w_alu_src    = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = c_RES_PC4;
                w_jump       = 1'b1;
                w_jalr       = 1'b1;
                w_legal      = 1'b1;
            end
            c_OP_LUI: begin
                w_imm_src   = c_IMM_U;
                w_alu_src   = 1'b1;
                w_alu_ctrl  = c_ALU_PASS;
                w_reg_write = 1'b1;
                w_legal     = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal instructions travel as NOPs; a flush replaces the capture with a bubble
    always_comb begin
        reg_write_e_d  = w_reg_write & w_legal;
        mem_write_e_d  = w_mem_write & w_legal;
        jump_e_d       = w_jump & w_legal;
        branch_e_d     = w_branch & w_legal;
        jalr_e_d       = w_jalr;
        alu_src_e_d    = w_alu_src;
        result_src_e_d = w_result_src;
        alu_ctrl_e_d   = w_alu_ctrl;
        branch_f3_e_d  = bus.funct3;
        if (bus.FlushE) begin
            reg_write_e_d  = 1'b0;
            mem_write_e_d  = 1'b0;
            jump_e_d       = 1'b0;
            branch_e_d     = 1'b0;
            jalr_e_d       = 1'b0;
            alu_src_e_d    = 1'b0;
            result_src_e_d = 2'b00;
            alu_ctrl_e_d   = 3'b000;
            branch_f3_e_d  = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_e_q  <= 1'b0;
            mem_write_e_q  <= 1'b0;
            jump_e_q       <= 1'b0;
            branch_e_q     <= 1'b0;
            jalr_e_q       <= 1'b0;
            alu_src_e_q    <= 1'b0;
            result_src_e_q <= 2'b00;
            alu_ctrl_e_q   <= 3'b000;
            branch_f3_e_q  <= 3'b000;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= 2'b00;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 2'b00;
        end else begin
            reg_write_e_q  <= reg_write_e_d;
            mem_write_e_q  <= mem_write_e_d;
            jump_e_q       <= jump_e_d;
            branch_e_q     <= branch_e_d;
            jalr_e_q       <= jalr_e_d;
            alu_src_e_q    <= alu_src_e_d;
            result_src_e_q <= result_src_e_d;
            alu_ctrl_e_q   <= alu_ctrl_e_d;
            branch_f3_e_q  <= branch_f3_e_d;
            reg_write_m_q  <= reg_write_e_q;
            mem_write_m_q  <= mem_write_e_q;
            result_src_m_q <= result_src_e_q;
            reg_write_w_q  <= reg_write_m_q;
            result_src_w_q <= result_src_m_q;
        end
    end

    // slt/sltu produce zero when "not less", so blt/bltu take on !Z and bge/bgeu on Z
    always_comb begin
        w_taken = 1'b0;
        case (branch_f3_e_q)
            3'b000:         w_taken = bus.ZeroE;
            3'b001:         w_taken = ~bus.ZeroE;
            3'b100, 3'b110: w_taken = ~bus.ZeroE;
            3'b101, 3'b111: w_taken = bus.ZeroE;
            default:        w_taken = 1'b0;
        endcase
    end

    assign bus.ImmSrcD     = w_imm_src;
    assign bus.IllegalD    = ~w_legal;
    assign bus.ALUSrcE     = alu_src_e_q;
    assign bus.ALUControlE = alu_ctrl_e_q;
    assign bus.jalrE       = jalr_e_q;
    assign bus.PCSrcE      = jump_e_q | (branch_e_q & w_taken);
    assign bus.ResultSrcE0 = result_src_e_q[0];
    assign bus.MemWriteM   = mem_write_m_q;
    assign bus.RegWriteM   = reg_write_m_q;
    assign bus.RegWriteW   = reg_write_w_q;
    assign bus.ResultSrcW  = result_src_w_q;

endmodule

`default_nettype wire
